// File: rtl/sbi_pkg.sv
// Shared types for the SBI burst master: the control FSM state encoding.
package sbi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BURST = 2'd2,
    DRAIN = 2'd3
  } sbi_state_e;

endpackage

// File: rtl/sbi_beat_cnt.sv
// Loadable down-counter with a zero flag; tracks beats still to issue or to return.
module sbi_beat_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sbi_burst_master.sv
// SBI bus master: turns one request into a START cycle plus incrementing-address
// beats; write beats come from a valid/ready stream, read beats return on rd_*.
module sbi_burst_master
  import sbi_pkg::*;
#(
  parameter int Width    = 32,
  parameter int Depth    = 256,
  parameter int MaxBurst = 16,
  localparam int Aw      = $clog2(Depth),
  localparam int Lw      = $clog2(MaxBurst)
) (
  input  logic             bCLK,
  input  logic             bRST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [Aw-1:0]    req_addr,
  input  logic [Lw-1:0]    req_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [Width-1:0] wr_data,
  output logic             rd_valid,
  output logic [Width-1:0] rd_data,
  output logic             done,
  output logic             busy,
  output logic [Aw-1:0]    bADDR,
  output logic             bSTART,
  output logic             bACCESS,
  output logic             bWRITE,
  output logic [Width-1:0] bD,
  input  logic [Width-1:0] bQ,
  input  logic             bVALID
);

  localparam int Cw = Lw + 1;

  sbi_state_e     state, nextState;
  logic [Aw-1:0]    addrQ;
  logic             writeQ;
  logic [Width-1:0] dataQ;
  logic             doneQ;

  logic [Cw-1:0] issueCnt, retCnt;
  logic          issueZero, retZero;
  logic          accept, beat, retAccept, lastRet;
  logic [Cw-1:0] lenPlusOne;

  assign accept     = req_valid && req_ready;
  assign lenPlusOne = {1'b0, req_len} + Cw'(1);
  assign beat       = (state == BURST) && !issueZero && (writeQ ? wr_valid : 1'b1);
  // Returns are only meaningful for a read burst that still expects data.
  assign retAccept  = bVALID && !writeQ && ((state == BURST) || (state == DRAIN)) && !retZero;
  assign lastRet    = retAccept && (retCnt == Cw'(1));

  sbi_beat_cnt #(.W(Cw)) u_issueCnt (
    .clk     (bCLK),
    .rst     (bRST),
    .load    (accept),
    .loadVal (lenPlusOne),
    .dec     (beat),
    .count   (issueCnt),
    .zero    (issueZero)
  );

  sbi_beat_cnt #(.W(Cw)) u_retCnt (
    .clk     (bCLK),
    .rst     (bRST),
    .load    (accept),
    .loadVal (lenPlusOne),
    .dec     (retAccept),
    .count   (retCnt),
    .zero    (retZero)
  );

  // NOTE: nextState gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (accept) nextState = START;
      START:   nextState = BURST;
      BURST:   if (beat && (issueCnt == Cw'(1))) nextState = writeQ ? IDLE : DRAIN;
      DRAIN:   if (retZero || lastRet) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge bCLK or posedge bRST) begin
    if (bRST) begin
      state  <= IDLE;
      doneQ  <= 1'b0;
      addrQ  <= '0;
      writeQ <= 1'b0;
      dataQ  <= '0;
    end else begin
      state <= nextState;
      doneQ <= (state != IDLE) && (nextState == IDLE);
      if (accept) begin
        addrQ  <= req_addr;
        writeQ <= req_write;
      end else if (beat) begin
        // Wrap explicitly so non-power-of-two depths stay in range.
        addrQ <= (addrQ == Aw'(Depth - 1)) ? '0 : addrQ + 1'b1;
      end
      if (beat && writeQ) dataQ <= wr_data;
    end
  end

  assign req_ready = (state == IDLE) && !bRST;
  assign wr_ready  = (state == BURST) && writeQ;
  assign rd_valid  = retAccept;
  assign rd_data   = retAccept ? bQ : '0;
  assign done      = doneQ;
  assign busy      = (state != IDLE);
  assign bADDR     = addrQ;
  assign bSTART    = (state == START);
  assign bACCESS   = beat;
  assign bWRITE    = writeQ;
  assign bD        = (beat && writeQ) ? wr_data : dataQ;

endmodule

// File: tb/tb_sbi_burst_master.sv
// Directed bench for sbi_burst_master with a latency-1 SBI slave model and
// scoreboard queues for start cycles, bus accesses and read returns.
module tb_sbi_burst_master;

  localparam int Width    = 32;
  localparam int Depth    = 256;
  localparam int MaxBurst = 16;
  localparam int Aw       = 8;
  localparam int Lw       = 4;

  typedef struct packed {
    logic [Aw-1:0]    addr;
    logic             wr;
    logic [Width-1:0] data;
  } acc_t;

  logic             bCLK = 1'b0;
  logic             bRST = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_write = 1'b0;
  logic [Aw-1:0]    req_addr = '0;
  logic [Lw-1:0]    req_len = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [Width-1:0] wr_data = '0;
  logic             rd_valid;
  logic [Width-1:0] rd_data;
  logic             done;
  logic             busy;
  logic [Aw-1:0]    bADDR;
  logic             bSTART;
  logic             bACCESS;
  logic             bWRITE;
  logic [Width-1:0] bD;
  logic [Width-1:0] bQ;
  logic             bVALID;
  logic             spur = 1'b0;

  int cyc = 0;
  int nCompared = 0;
  int nMismatched = 0;

  logic [Aw-1:0]    expStart[$];
  acc_t             expAcc[$];
  logic [Width-1:0] expRd[$];
  int               startLog[$];
  int               doneLog[$];
  int               accInBurst = 0;
  int               firstAcc = 0;

  logic [Width-1:0] mem [Depth];
  bit               wrote [Depth];
  logic [Width-1:0] refMem [Depth];

  always #5 bCLK = ~bCLK;
  always @(posedge bCLK) cyc <= cyc + 1;

  sbi_burst_master #(.Width(Width), .Depth(Depth), .MaxBurst(MaxBurst)) dut (
    .bCLK      (bCLK),
    .bRST      (bRST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .done      (done),
    .busy      (busy),
    .bADDR     (bADDR),
    .bSTART    (bSTART),
    .bACCESS   (bACCESS),
    .bWRITE    (bWRITE),
    .bD        (bD),
    .bQ        (bQ),
    .bVALID    (bVALID)
  );

  function automatic logic [Width-1:0] initVal(input int i);
    return 32'hC0DE_0000 | Width'(i);
  endfunction

  function automatic logic [Width-1:0] slaveRead(input logic [Aw-1:0] a);
    return wrote[a] ? mem[a] : initVal(int'(a));
  endfunction

  // Slave model: one-cycle read latency; spur injects an extra bVALID.
  always @(posedge bCLK or posedge bRST) begin
    if (bRST) begin
      bVALID <= 1'b0;
      bQ     <= '0;
    end else begin
      bVALID <= (bACCESS && !bWRITE) || spur;
      bQ     <= (bACCESS && !bWRITE) ? slaveRead(bADDR) : 32'h0BAD_0BAD;
      if (bACCESS && bWRITE) begin
        mem[bADDR]   <= bD;
        wrote[bADDR] <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor pops scoreboard entries whenever the DUT produces an output.
  always @(negedge bCLK) begin : monitor
    acc_t          e;
    logic [Aw-1:0] a;
    if (!bRST) begin
      if (bSTART) begin
        startLog.push_back(cyc);
        accInBurst <= 0;
        check("start_expected", expStart.size() != 0, 1);
        if (expStart.size() != 0) begin
          a = expStart.pop_front();
          check("start_addr", bADDR, a);
        end
      end
      if (bACCESS) begin
        if (accInBurst == 0) firstAcc <= cyc;
        accInBurst <= accInBurst + 1;
        check("acc_expected", expAcc.size() != 0, 1);
        if (expAcc.size() != 0) begin
          e = expAcc.pop_front();
          check("acc_addr", bADDR, e.addr);
          check("acc_write", bWRITE, e.wr);
          if (e.wr) check("acc_data", bD, e.data);
        end
      end
      if (rd_valid) begin
        check("rd_expected", expRd.size() != 0, 1);
        if (expRd.size() != 0) check("rd_data", rd_data, expRd.pop_front());
      end
      if (done) doneLog.push_back(cyc);
    end
  end

  task automatic sample();
    @(negedge bCLK);
    #1;
  endtask

  task automatic driveEdge();
    @(posedge bCLK);
    #1;
  endtask

  task automatic pushRead(input logic [Aw-1:0] a, input int l);
    logic [Aw-1:0] ad;
    expStart.push_back(a);
    for (int i = 0; i <= l; i++) begin
      ad = a + Aw'(i);
      expAcc.push_back('{addr: ad, wr: 1'b0, data: '0});
      expRd.push_back(refMem[ad]);
    end
  endtask

  task automatic pushWrite(input logic [Aw-1:0] a, input int l, input logic [Width-1:0] base);
    logic [Aw-1:0]    ad;
    logic [Width-1:0] d;
    expStart.push_back(a);
    for (int i = 0; i <= l; i++) begin
      ad = a + Aw'(i);
      d  = base + Width'(i);
      refMem[ad] = d;
      expAcc.push_back('{addr: ad, wr: 1'b1, data: d});
    end
  endtask

  task automatic issue(input logic w, input logic [Aw-1:0] a, input logic [Lw-1:0] l, output int acc);
    int n;
    driveEdge();
    req_write = w;
    req_addr  = a;
    req_len   = l;
    req_valid = 1'b1;
    n = 0;
    sample();
    while (!req_ready && n < 50) begin
      sample();
      n++;
    end
    check("req_accept", req_ready, 1);
    acc = cyc;
    driveEdge();
    req_valid = 1'b0;
  endtask

  task automatic sendData(input logic [Width-1:0] base, input int n, input int stallAfter,
                          input int stallLen, input logic [Aw-1:0] heldAddr);
    int k;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + Width'(i);
      k = 0;
      sample();
      while (!wr_ready && k < 50) begin
        sample();
        k++;
      end
      check("wr_ready", wr_ready, 1);
      driveEdge();
      if (i == stallAfter) begin
        wr_valid = 1'b0;
        for (int s = 0; s < stallLen; s++) begin
          sample();
          check("stall_noacc", bACCESS, 0);
          check("stall_addr", bADDR, heldAddr);
          driveEdge();
        end
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic waitDone(input int idx);
    int k = 0;
    while (doneLog.size() <= idx && k < 100) begin
      sample();
      k++;
    end
    check("done_seen", doneLog.size() > idx, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int acc, acc1, acc2, dc, n, k, firstDone;
    for (int i = 0; i < Depth; i++) refMem[i] = initVal(i);

    // Reset state
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_bACCESS", bACCESS, 0);
    check("rst_bSTART", bSTART, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    driveEdge();
    driveEdge();
    bRST = 1'b0;
    sample();
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_busy", busy, 0);

    // Read 4 beats at 0x10
    pushRead(8'h10, 3);
    dc = doneLog.size();
    issue(1'b0, 8'h10, 4'd3, acc);
    waitDone(dc);
    check("rd_start_lat", startLog[$], acc + 1);
    check("rd_first_acc", firstAcc, acc + 2);
    check("rd_beats", accInBurst, 4);
    check("rd_done_lat", doneLog[$], acc + 7);
    sample();
    check("rd_single_done", doneLog.size(), dc + 1);
    check("rd_queue_empty", expRd.size(), 0);

    // Write 4 beats across the address wrap
    pushWrite(8'hFE, 3, 32'hA0);
    dc = doneLog.size();
    issue(1'b1, 8'hFE, 4'd3, acc);
    sendData(32'hA0, 4, -1, 0, '0);
    waitDone(dc);
    check("wr_beats", accInBurst, 4);
    check("wr_done_lat", doneLog[$], acc + 6);

    // Read back the wrapped write
    pushRead(8'hFE, 3);
    dc = doneLog.size();
    issue(1'b0, 8'hFE, 4'd3, acc);
    waitDone(dc);
    check("rb_done_lat", doneLog[$], acc + 7);
    check("rb_queue_empty", expRd.size(), 0);

    // Write 3 beats with a 2-cycle stall after the first beat
    pushWrite(8'h80, 2, 32'hB0);
    dc = doneLog.size();
    issue(1'b1, 8'h80, 4'd2, acc);
    sendData(32'hB0, 3, 0, 2, 8'h81);
    waitDone(dc);
    check("stall_beats", accInBurst, 3);
    check("stall_done_lat", doneLog[$], acc + 7);

    // Spurious bVALID while idle
    dc = doneLog.size();
    driveEdge();
    spur = 1'b1;
    driveEdge();
    spur = 1'b0;
    sample();
    check("idle_spur_bvalid", bVALID, 1);
    check("idle_spur_rd_valid", rd_valid, 0);
    check("idle_spur_busy", busy, 0);
    check("idle_spur_no_done", doneLog.size(), dc);

    // Fifth bVALID after a 4-beat read lands in the done cycle
    pushRead(8'h10, 3);
    dc = doneLog.size();
    issue(1'b0, 8'h10, 4'd3, acc);
    for (int i = 0; i < 5; i++) driveEdge();
    spur = 1'b1;
    driveEdge();
    spur = 1'b0;
    sample();
    check("extra_bvalid", bVALID, 1);
    check("extra_rd_valid", rd_valid, 0);
    check("extra_done", done, 1);
    check("extra_done_cycle", cyc, acc + 7);
    sample();
    check("extra_busy", busy, 0);
    check("extra_single_done", doneLog.size(), dc + 1);
    check("extra_queue_empty", expRd.size(), 0);

    // Reset during beat 2 of an 8-beat read
    pushRead(8'h40, 7);
    issue(1'b0, 8'h40, 4'd7, acc);
    n = 0;
    k = 0;
    while (n < 2 && k < 50) begin
      sample();
      if (bACCESS) n++;
      k++;
    end
    check("abort_reached_beat2", n, 2);
    dc = doneLog.size();
    bRST = 1'b1;
    #1;
    check("abort_bACCESS", bACCESS, 0);
    check("abort_bSTART", bSTART, 0);
    check("abort_busy", busy, 0);
    check("abort_req_ready", req_ready, 0);
    check("abort_rd_valid", rd_valid, 0);
    check("abort_done", done, 0);
    check("abort_bADDR", bADDR, 0);
    check("abort_bD", bD, 0);
    check("abort_bWRITE", bWRITE, 0);
    check("abort_wr_ready", wr_ready, 0);
    expAcc.delete();
    expRd.delete();
    driveEdge();
    driveEdge();
    bRST = 1'b0;
    sample();
    check("abort_no_done", doneLog.size(), dc);
    check("abort_idle", busy, 0);

    // Single-beat read after the abort
    pushRead(8'h33, 0);
    dc = doneLog.size();
    issue(1'b0, 8'h33, 4'd0, acc);
    waitDone(dc);
    check("len0_done_lat", doneLog[$], acc + 4);
    check("len0_beats", accInBurst, 1);

    // Back-to-back requests with req_valid held high
    pushRead(8'h20, 1);
    pushRead(8'h30, 0);
    dc = doneLog.size();
    driveEdge();
    req_write = 1'b0;
    req_addr  = 8'h20;
    req_len   = 4'd1;
    req_valid = 1'b1;
    sample();
    check("b2b_first_ready", req_ready, 1);
    acc1 = cyc;
    driveEdge();
    req_addr = 8'h30;
    req_len  = 4'd0;
    k = 0;
    sample();
    while (!req_ready && k < 50) begin
      sample();
      k++;
    end
    check("b2b_second_ready", req_ready, 1);
    acc2 = cyc;
    check("b2b_first_done_seen", doneLog.size(), dc + 1);
    firstDone = (doneLog.size() > dc) ? doneLog[dc] : -1;
    driveEdge();
    req_valid = 1'b0;
    check("b2b_first_done_lat", firstDone, acc1 + 5);
    check("b2b_accept_in_done", acc2, firstDone);
    waitDone(dc + 1);
    check("b2b_second_start", startLog[$], firstDone + 1);
    check("b2b_second_done_lat", doneLog[$], acc2 + 4);

    sample();
    check("end_start_queue", expStart.size(), 0);
    check("end_acc_queue", expAcc.size(), 0);
    check("end_rd_queue", expRd.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
